// File: rtl/hsi_m_rx_ctrl_pkg.sv
// Shared HSI master config: command-type one-hot positions, CRC seed and RX FSM states.
package hsi_m_rx_ctrl_pkg;

  localparam int ARM_SR_BIT  = 0;
  localparam int ARM_DPR_BIT = 1;
  localparam int ARM_CCW_BIT = 2;

  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FIRST,
    ST_PAYLOAD,
    ST_CRC_HI,
    ST_CRC_LO,
    ST_CHECK
  } rx_state_e;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/hsi_m_rx_ctrl_crc16.sv
// One-byte CRC16-CCITT step (poly 0x1021, MSB first, no reflection); shared with the TX CRC path.
module crc16_ccitt_byte (
  input  logic [15:0] crc_in,
  input  logic [7:0]  d,
  output logic [15:0] crc_out
);

  always_comb begin
    logic [15:0] c;
    c = crc_in ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/hsi_m_rx_ctrl.sv
// Master-side HSI reply receiver: frames a fixed-length reply after arm, checks CRC, reports one status per window.
module hsi_m_rx_ctrl
  import hsi_m_rx_ctrl_pkg::*;
#(
  parameter int unsigned LEN_SR   = 4,
  parameter int unsigned LEN_DPR  = 8,
  parameter int unsigned LEN_CCW  = 9,
  parameter int unsigned FIRST_TO = 20000,
  parameter int unsigned GAP_TO   = 2000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       arm,
  input  logic [2:0] arm_type,
  input  logic [7:0] dec_byte,
  input  logic       dec_byte_rdy,
  input  logic       dec_err,
  output logic [7:0] rx_byte,
  output logic       rx_byte_vld,
  output logic [2:0] rx_type,
  output logic       rx_busy,
  output logic       rx_msg_ok,
  output logic       rx_crc_err,
  output logic       rx_frame_err,
  output logic       rx_timeout,
  output logic       rx_unexp
);

  localparam logic [7:0]  LEN_SR_B   = 8'(LEN_SR);
  localparam logic [7:0]  LEN_DPR_B  = 8'(LEN_DPR);
  localparam logic [7:0]  LEN_CCW_B  = 8'(LEN_CCW);
  localparam logic [15:0] FIRST_LIM  = 16'(FIRST_TO - 1);
  localparam logic [15:0] GAP_LIM    = 16'(GAP_TO - 1);

  rx_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] crc_q, crc_d, crc_step;
  logic [2:0]  type_d;
  logic [7:0]  byte_d;
  logic        vld_d, ok_d, crce_d, fe_d, to_d, unexp_d;
  logic [7:0]  len_sel;
  logic [15:0] to_lim;

  crc16_ccitt_byte u_crc (
    .crc_in  (crc_q),
    .d       (dec_byte),
    .crc_out (crc_step)
  );

  always_comb begin
    len_sel = 8'd0;
    if (arm_type[ARM_SR_BIT])  len_sel = LEN_SR_B;
    if (arm_type[ARM_DPR_BIT]) len_sel = LEN_DPR_B;
    if (arm_type[ARM_CCW_BIT]) len_sel = LEN_CCW_B;
  end

  assign to_lim = (state_q == ST_WAIT_FIRST) ? FIRST_LIM : GAP_LIM;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q + 16'd1;
    crc_d   = crc_q;
    type_d  = rx_type;
    byte_d  = rx_byte;
    vld_d   = 1'b0;
    ok_d    = 1'b0;
    crce_d  = 1'b0;
    fe_d    = 1'b0;
    to_d    = 1'b0;
    unexp_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        timer_d = timer_q;
        unexp_d = dec_byte_rdy;
        if (arm && is_onehot3(arm_type)) begin
          state_d = ST_WAIT_FIRST;
          type_d  = arm_type;
          cnt_d   = len_sel;
          crc_d   = CRC16_INIT;
          timer_d = 16'd0;
        end
      end
      ST_WAIT_FIRST, ST_PAYLOAD: begin
        if (dec_byte_rdy) begin
          byte_d  = dec_byte;
          vld_d   = 1'b1;
          crc_d   = crc_step;
          cnt_d   = cnt_q - 8'd1;
          timer_d = 16'd0;
          state_d = (cnt_q == 8'd1) ? ST_CRC_HI : ST_PAYLOAD;
        end else if (timer_q == to_lim) begin
          to_d    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_CRC_HI, ST_CRC_LO: begin
        if (dec_byte_rdy) begin
          crc_d   = crc_step;
          timer_d = 16'd0;
          state_d = (state_q == ST_CRC_HI) ? ST_CRC_LO : ST_CHECK;
        end else if (timer_q == to_lim) begin
          to_d    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        timer_d = 16'd0;
        unexp_d = dec_byte_rdy;
        ok_d    = (crc_q == 16'h0000);
        crce_d  = (crc_q != 16'h0000);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A code violation closes the window and suppresses any byte or status from this cycle.
    if (dec_err && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      byte_d  = rx_byte;
      vld_d   = 1'b0;
      ok_d    = 1'b0;
      crce_d  = 1'b0;
      to_d    = 1'b0;
      fe_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      timer_q      <= 16'd0;
      crc_q        <= CRC16_INIT;
      rx_type      <= 3'b000;
      rx_byte      <= 8'h00;
      rx_byte_vld  <= 1'b0;
      rx_msg_ok    <= 1'b0;
      rx_crc_err   <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_timeout   <= 1'b0;
      rx_unexp     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      crc_q        <= crc_d;
      rx_type      <= type_d;
      rx_byte      <= byte_d;
      rx_byte_vld  <= vld_d;
      rx_msg_ok    <= ok_d;
      rx_crc_err   <= crce_d;
      rx_frame_err <= fe_d;
      rx_timeout   <= to_d;
      rx_unexp     <= unexp_d;
    end
  end

  assign rx_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hsi_m_rx_ctrl.sv
// Directed-vector bench for hsi_m_rx_ctrl: table of per-cycle stimulus/expectation plus timeout and reset sequences.
module tb_hsi_m_rx_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       arm;
  logic [2:0] arm_type;
  logic [7:0] dec_byte;
  logic       dec_byte_rdy;
  logic       dec_err;
  logic [7:0] rx_byte;
  logic       rx_byte_vld;
  logic [2:0] rx_type;
  logic       rx_busy, rx_msg_ok, rx_crc_err, rx_frame_err, rx_timeout, rx_unexp;

  int n_chk  = 0;
  int n_fail = 0;

  hsi_m_rx_ctrl #(
    .LEN_SR(4), .LEN_DPR(8), .LEN_CCW(9), .FIRST_TO(16), .GAP_TO(8)
  ) dut (
    .clk(clk), .n_rst(n_rst), .arm(arm), .arm_type(arm_type),
    .dec_byte(dec_byte), .dec_byte_rdy(dec_byte_rdy), .dec_err(dec_err),
    .rx_byte(rx_byte), .rx_byte_vld(rx_byte_vld), .rx_type(rx_type), .rx_busy(rx_busy),
    .rx_msg_ok(rx_msg_ok), .rx_crc_err(rx_crc_err), .rx_frame_err(rx_frame_err),
    .rx_timeout(rx_timeout), .rx_unexp(rx_unexp)
  );

  always #5 clk = ~clk;

  // status field order: {ok, crc_err, frame_err, timeout, unexp}
  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_OK   = 5'b10000;
  localparam logic [4:0] S_CRCE = 5'b01000;
  localparam logic [4:0] S_FE   = 5'b00100;
  localparam logic [4:0] S_TO   = 5'b00010;
  localparam logic [4:0] S_UNX  = 5'b00001;

  typedef struct packed {
    logic       arm;
    logic [2:0] atype;
    logic       rdy;
    logic [7:0] b;
    logic       err;
    logic       vld;
    logic [7:0] eb;
    logic       busy;
    logic [2:0] etype;
    logic [4:0] st;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t row(input logic a, input logic [2:0] at, input logic r, input logic [7:0] b,
                               input logic e, input logic v, input logic [7:0] eb, input logic bz,
                               input logic [2:0] et, input logic [4:0] st);
    vec_t x;
    x.arm = a; x.atype = at; x.rdy = r; x.b = b; x.err = e;
    x.vld = v; x.eb = eb; x.busy = bz; x.etype = et; x.st = st;
    return x;
  endfunction

  function automatic vec_t idle(input logic bz, input logic [2:0] et, input logic [4:0] st);
    return row(1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, bz, et, st);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input string name, input vec_t v);
    arm = v.arm; arm_type = v.atype; dec_byte_rdy = v.rdy; dec_byte = v.b; dec_err = v.err;
    @(posedge clk);
    #1;
    arm = 1'b0; arm_type = 3'b000; dec_byte_rdy = 1'b0; dec_byte = 8'h00; dec_err = 1'b0;
    chk({name, ".vld"}, 32'(rx_byte_vld), 32'(v.vld));
    if (v.vld) chk({name, ".byte"}, 32'(rx_byte), 32'(v.eb));
    chk({name, ".busy"}, 32'(rx_busy), 32'(v.busy));
    chk({name, ".type"}, 32'(rx_type), 32'(v.etype));
    chk({name, ".status"}, 32'({rx_msg_ok, rx_crc_err, rx_frame_err, rx_timeout, rx_unexp}), 32'(v.st));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, ".outs"},
        32'({rx_byte, rx_byte_vld, rx_type, rx_busy, rx_msg_ok, rx_crc_err, rx_frame_err, rx_timeout, rx_unexp}),
        32'd0);
  endtask

  task automatic push_ccw_frame(input logic [7:0] crc_lo, input logic [4:0] st);
    tv.push_back(row(1, 3'b100, 0, 8'h00, 0, 0, 8'h00, 1, 3'b100, S_NONE));
    for (int i = 0; i < 9; i++) begin
      // a stray SR arm on byte 4 must not disturb the open window
      tv.push_back(row(i == 3, 3'b001, 1, 8'(8'h31 + i), 0, 1, 8'(8'h31 + i), 1, 3'b100, S_NONE));
    end
    tv.push_back(row(0, 3'b000, 1, 8'h29, 0, 0, 8'h00, 1, 3'b100, S_NONE));
    tv.push_back(row(0, 3'b000, 1, crc_lo, 0, 0, 8'h00, 1, 3'b100, S_NONE));
    tv.push_back(idle(0, 3'b100, st));
    tv.push_back(idle(0, 3'b100, S_NONE));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0;
    arm = 1'b0; arm_type = 3'b000; dec_byte = 8'h00; dec_byte_rdy = 1'b0; dec_err = 1'b0;
    #12;
    chk_reset_outputs("reset");
    n_rst = 1'b1;

    // table: strobe in idle, non-one-hot arm, good/bad CCW frames, frame error, arm+strobe
    tv.push_back(row(0, 3'b000, 1, 8'h55, 0, 0, 8'h00, 0, 3'b000, S_UNX));
    tv.push_back(row(1, 3'b011, 0, 8'h00, 0, 0, 8'h00, 0, 3'b000, S_NONE));
    tv.push_back(idle(0, 3'b000, S_NONE));
    push_ccw_frame(8'hB1, S_OK);
    push_ccw_frame(8'hB0, S_CRCE);
    tv.push_back(row(1, 3'b001, 0, 8'h00, 0, 0, 8'h00, 1, 3'b001, S_NONE));
    tv.push_back(row(0, 3'b000, 1, 8'hA1, 0, 1, 8'hA1, 1, 3'b001, S_NONE));
    tv.push_back(row(0, 3'b000, 1, 8'hA2, 0, 1, 8'hA2, 1, 3'b001, S_NONE));
    tv.push_back(row(0, 3'b000, 1, 8'hA3, 1, 0, 8'h00, 0, 3'b001, S_FE));
    tv.push_back(row(0, 3'b000, 1, 8'h77, 0, 0, 8'h00, 0, 3'b001, S_UNX));
    tv.push_back(row(1, 3'b010, 1, 8'h66, 0, 0, 8'h00, 1, 3'b010, S_UNX));
    tv.push_back(row(0, 3'b000, 0, 8'h00, 1, 0, 8'h00, 0, 3'b010, S_FE));
    tv.push_back(row(0, 3'b000, 0, 8'h00, 1, 0, 8'h00, 0, 3'b010, S_NONE));

    for (int i = 0; i < tv.size(); i++) apply($sformatf("vec%0d", i), tv[i]);

    // first-byte timeout: pulse exactly 16 cycles after arm
    apply("to_arm", row(1, 3'b001, 0, 8'h00, 0, 0, 8'h00, 1, 3'b001, S_NONE));
    for (int i = 1; i < 16; i++) apply($sformatf("to_wait%0d", i), idle(1, 3'b001, S_NONE));
    apply("to_fire", idle(0, 3'b001, S_TO));

    // strobe on the timeout cycle wins, then gap timeout 8 cycles later
    apply("sw_arm", row(1, 3'b100, 0, 8'h00, 0, 0, 8'h00, 1, 3'b100, S_NONE));
    for (int i = 1; i < 16; i++) apply($sformatf("sw_wait%0d", i), idle(1, 3'b100, S_NONE));
    apply("sw_byte", row(0, 3'b000, 1, 8'hAA, 0, 1, 8'hAA, 1, 3'b100, S_NONE));
    for (int i = 1; i < 8; i++) apply($sformatf("sw_gap%0d", i), idle(1, 3'b100, S_NONE));
    apply("sw_to", idle(0, 3'b100, S_TO));

    // SR: two bytes then silence
    apply("gap_arm", row(1, 3'b001, 0, 8'h00, 0, 0, 8'h00, 1, 3'b001, S_NONE));
    apply("gap_b1", row(0, 3'b000, 1, 8'h11, 0, 1, 8'h11, 1, 3'b001, S_NONE));
    apply("gap_b2", row(0, 3'b000, 1, 8'h12, 0, 1, 8'h12, 1, 3'b001, S_NONE));
    for (int i = 1; i < 8; i++) apply($sformatf("gap_wait%0d", i), idle(1, 3'b001, S_NONE));
    apply("gap_to", idle(0, 3'b001, S_TO));

    // reset mid-payload: immediate abort, no status afterwards
    apply("rst_arm", row(1, 3'b010, 0, 8'h00, 0, 0, 8'h00, 1, 3'b010, S_NONE));
    apply("rst_b1", row(0, 3'b000, 1, 8'hC1, 0, 1, 8'hC1, 1, 3'b010, S_NONE));
    apply("rst_b2", row(0, 3'b000, 1, 8'hC2, 0, 1, 8'hC2, 1, 3'b010, S_NONE));
    n_rst = 1'b0;
    #2;
    chk_reset_outputs("rst_mid");
    n_rst = 1'b1;
    for (int i = 0; i < 10; i++) apply($sformatf("rst_after%0d", i), idle(0, 3'b000, S_NONE));
    apply("rst_idle_strobe", row(0, 3'b000, 1, 8'h5A, 0, 0, 8'h00, 0, 3'b000, S_UNX));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
